// File: rtl/divisor_restaurador.sv
// Restoring divider, one quotient bit per clock, Start/Ready handshake.
// Define DIV_SIGNED_EN for two's complement operands (adds a FIX state).
module divisor_restaurador #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [BITS-1:0] Dividendo,
  input  logic [BITS-1:0] Divisor,
  output logic [BITS-1:0] Cociente,
  output logic [BITS-1:0] Residuo,
  output logic            Ready,
  output logic            DivCero
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          st, st_n;
  logic [BITS-1:0] q, r, d;
  logic [CW-1:0]   cnt;
  logic            dz;
  logic            last;
  logic [BITS:0]   rs;
  logic            ge;
  logic [BITS-1:0] q_n, r_n;
  logic [BITS-1:0] a_mag, b_mag;
`ifdef DIV_SIGNED_EN
  logic            nq, nr;
`endif

  assign last = (cnt == CW'(BITS-1));

`ifdef DIV_SIGNED_EN
  assign a_mag = Dividendo[BITS-1] ? -Dividendo : Dividendo;
  assign b_mag = Divisor[BITS-1] ? -Divisor : Divisor;
`else
  assign a_mag = Dividendo;
  assign b_mag = Divisor;
`endif

  // r < d always holds, so the restored remainder fits in BITS bits
  always_comb begin
    rs  = {r, q[BITS-1]};
    ge  = (rs >= {1'b0, d});
    r_n = ge ? BITS'(rs - {1'b0, d}) : rs[BITS-1:0];
    q_n = {q[BITS-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE: if (Start) st_n = DIV;
      DIV: begin
        if (dz)
          st_n = DONE;
        else if (last)
`ifdef DIV_SIGNED_EN
          st_n = FIX;
`else
          st_n = DONE;
`endif
      end
      FIX:  st_n = DONE;
      DONE: if (!Start) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      r        <= '0;
      d        <= '0;
      cnt      <= '0;
      dz       <= 1'b0;
`ifdef DIV_SIGNED_EN
      nq       <= 1'b0;
      nr       <= 1'b0;
`endif
      Cociente <= '0;
      Residuo  <= '0;
      Ready    <= 1'b0;
      DivCero  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (Start) begin
            cnt <= '0;
            d   <= b_mag;
            dz  <= (Divisor == '0);
`ifdef DIV_SIGNED_EN
            nq  <= Dividendo[BITS-1] ^ Divisor[BITS-1];
            nr  <= Dividendo[BITS-1];
`endif
            // zero divisor: preload the final answer
            if (Divisor == '0) begin
              q <= '1;
              r <= Dividendo;
            end else begin
              q <= a_mag;
              r <= '0;
            end
          end
        end
        DIV: begin
          if (dz) begin
            Cociente <= q;
            Residuo  <= r;
            DivCero  <= 1'b1;
            Ready    <= 1'b1;
          end else begin
            q   <= q_n;
            r   <= r_n;
            cnt <= cnt + 1'b1;
`ifndef DIV_SIGNED_EN
            if (last) begin
              Cociente <= q_n;
              Residuo  <= r_n;
              Ready    <= 1'b1;
            end
`endif
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          Cociente <= nq ? -q : q;
          Residuo  <= nr ? -r : r;
`else
          Cociente <= q;
          Residuo  <= r;
`endif
          Ready    <= 1'b1;
        end
        DONE: begin
          if (!Start) begin
            Cociente <= '0;
            Residuo  <= '0;
            Ready    <= 1'b0;
            DivCero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
